// File: rtl/enigma_pkg.sv
// Shared constants, FSM state encoding and character helper for the Enigma
// stream driver.
package enigma_pkg;

  localparam int CHAR_W = 8;

  localparam logic [CHAR_W-1:0] ASCII_A = 8'h41;
  localparam logic [CHAR_W-1:0] ASCII_Z = 8'h5A;

  typedef enum logic [2:0] {
    S_UNCFG  = 3'd0,
    S_SET    = 3'd1,
    S_IDLE   = 3'd2,
    S_FETCH  = 3'd3,
    S_SEND   = 3'd4,
    S_WAIT   = 3'd5,
    S_BYPASS = 3'd6,
    S_EMIT   = 3'd7
  } state_t;

  // Only upper-case letters go through the cipher core.
  function automatic logic is_upper(input logic [CHAR_W-1:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output; DEPTH must be a power of two
// so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so push+pop on full keeps count.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + (AW + 1)'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/enigma_stream_driver.sv
// Host-side driver for the Enigma core: buffers host characters, sequences
// the set/valid/done handshake one character at a time and queues results.
module enigma_stream_driver
  import enigma_pkg::*;
#(
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_load,
  input  logic              dec_mode,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [CHAR_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_timeout,
  output logic              eng_set,
  output logic              eng_en,
  output logic              eng_valid,
  output logic [CHAR_W-1:0] eng_din,
  output logic              eng_dec,
  input  logic [CHAR_W-1:0] eng_dout,
  input  logic              eng_done
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [CHAR_W-1:0] cur_reg, cur_next;
  logic [CHAR_W-1:0] res_reg, res_next;
  logic              dec_reg, dec_next;
  logic              err_reg, err_next;
  logic [TW-1:0]     tmo_cnt_reg, tmo_cnt_next;
  logic              done_prev_reg;
  logic              done_rise;

  logic              in_full, in_empty, in_pop;
  logic [CHAR_W-1:0] in_head;
  logic              out_full, out_empty, out_push;
  logic [CHAR_W-1:0] out_head;

  sync_fifo #(.WIDTH(CHAR_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_valid & ~in_full),
    .push_data (in_data),
    .pop       (in_pop),
    .head      (in_head),
    .full      (in_full),
    .empty     (in_empty)
  );

  sync_fifo #(.WIDTH(CHAR_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (out_push),
    .push_data (res_reg),
    .pop       (out_ready & ~out_empty),
    .head      (out_head),
    .full      (out_full),
    .empty     (out_empty)
  );

  assign done_rise = eng_done & ~done_prev_reg;

  always_comb begin
    state_next   = state_reg;
    cur_next     = cur_reg;
    res_next     = res_reg;
    dec_next     = dec_reg;
    err_next     = err_reg;
    tmo_cnt_next = tmo_cnt_reg;
    in_pop       = 1'b0;
    out_push     = 1'b0;

    // Reconfiguration wins everywhere; anything in flight is simply dropped.
    if (cfg_load && state_reg != S_SET) begin
      state_next = S_SET;
      dec_next   = dec_mode;
    end else begin
      unique case (state_reg)
        S_UNCFG: ;
        S_SET: begin
          err_next   = 1'b0;
          state_next = S_IDLE;
        end
        S_IDLE: if (!in_empty) state_next = S_FETCH;
        S_FETCH: begin
          in_pop     = 1'b1;
          cur_next   = in_head;
          state_next = is_upper(in_head) ? S_SEND : S_BYPASS;
        end
        S_SEND: begin
          tmo_cnt_next = '0;
          state_next   = S_WAIT;
        end
        S_WAIT: begin
          if (done_rise) begin
            res_next   = eng_dout;
            state_next = S_EMIT;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            err_next   = 1'b1;
            state_next = S_IDLE;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + TW'(1);
          end
        end
        S_BYPASS: begin
          res_next   = cur_reg;
          state_next = S_EMIT;
        end
        S_EMIT: begin
          if (!out_full) begin
            out_push   = 1'b1;
            state_next = S_IDLE;
          end
        end
        default: state_next = S_UNCFG;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_UNCFG;
      cur_reg       <= '0;
      res_reg       <= '0;
      dec_reg       <= 1'b0;
      err_reg       <= 1'b0;
      tmo_cnt_reg   <= '0;
      done_prev_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cur_reg       <= cur_next;
      res_reg       <= res_next;
      dec_reg       <= dec_next;
      err_reg       <= err_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      done_prev_reg <= eng_done;
    end
  end

  assign in_ready    = ~in_full;
  assign out_valid   = ~out_empty;
  assign out_data    = out_empty ? '0 : out_head;
  // An unconfigured driver holding nothing is not considered busy.
  assign busy        = (state_reg != S_IDLE && state_reg != S_UNCFG) || !in_empty;
  assign err_timeout = err_reg;
  assign eng_set     = (state_reg == S_SET);
  assign eng_valid   = (state_reg == S_SEND);
  assign eng_en      = (state_reg == S_SEND) || (state_reg == S_WAIT);
  assign eng_din     = cur_reg;
  assign eng_dec     = dec_reg;

endmodule

// File: tb/tb_enigma_stream_driver.sv
// Randomized bench for enigma_stream_driver with a behavioural cipher-core
// model and an output scoreboard.
module tb_enigma_stream_driver;

  logic       clk;
  logic       rst_n;
  logic       cfg_load;
  logic       dec_mode;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       err_timeout;
  logic       eng_set;
  logic       eng_en;
  logic       eng_valid;
  logic [7:0] eng_din;
  logic       eng_dec;
  logic [7:0] eng_dout;
  logic       eng_done;

  enigma_stream_driver #(.IN_DEPTH(16), .OUT_DEPTH(16), .TIMEOUT(64)) dut (
    .clk         (clk),
    .reset_n     (rst_n),
    .cfg_load    (cfg_load),
    .dec_mode    (dec_mode),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .err_timeout (err_timeout),
    .eng_set     (eng_set),
    .eng_en      (eng_en),
    .eng_valid   (eng_valid),
    .eng_din     (eng_din),
    .eng_dec     (eng_dec),
    .eng_dout    (eng_dout),
    .eng_done    (eng_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  int         valid_cnt = 0;
  int         set_cnt = 0;
  int         core_lat = 5;
  logic       core_respond = 1'b1;
  logic       cur_dec = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour: letters are shifted by the core model, everything else passes through.
  function automatic logic [7:0] ref_xform(input logic [7:0] c, input logic dec);
    if (c >= 8'h41 && c <= 8'h5A) return dec ? c - 8'd1 : c + 8'd1;
    return c;
  endfunction

  // Cipher core model: answers din+1 (or din-1 when decrypting) core_lat cycles after valid.
  initial begin : core_model
    logic [7:0] din_l;
    logic       dec_l;
    logic       abort;
    eng_done = 1'b0;
    eng_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (eng_valid && core_respond) begin
        din_l = eng_din;
        dec_l = eng_dec;
        abort = 1'b0;
        for (int k = 0; k < core_lat && !abort; k++) begin
          @(negedge clk);
          if (eng_set) abort = 1'b1;
        end
        if (!abort) begin
          eng_dout = dec_l ? din_l - 8'd1 : din_l + 8'd1;
          eng_done = 1'b1;
          @(negedge clk);
          eng_done = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (eng_valid) valid_cnt++;
    if (eng_set) set_cnt++;
    if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_cfg(input logic dec);
    dec_mode = dec;
    cur_dec  = dec;
    cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
  endtask

  task automatic push_char(input logic [7:0] c);
    logic acc;
    in_valid = 1'b1;
    in_data  = c;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      push_char(s[i]);
      exp_q.push_back(ref_xform(s[i], cur_dec));
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (got_q.size() >= exp_q.size() && !busy) break;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int n);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (valid_cnt >= n) break;
    end
    check("valid_seen", 32'(valid_cnt), 32'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic compare_out(input string tag);
    int n;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [7:0] rc;
  logic       rnd_done;
  int         n_let;
  int         lat;
  logic [7:0] edge_tab[4];

  initial begin
    edge_tab[0] = 8'h40; edge_tab[1] = 8'h41; edge_tab[2] = 8'h5A; edge_tab[3] = 8'h5B;
    rst_n = 1'b0; cfg_load = 1'b0; dec_mode = 1'b0; in_valid = 1'b0;
    in_data = 8'h00; out_ready = 1'b1;
    tick(3);

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_eng_set", 32'(eng_set), 32'd0);
    check("rst_eng_en", 32'(eng_en), 32'd0);
    check("rst_eng_valid", 32'(eng_valid), 32'd0);
    check("rst_eng_din", 32'(eng_din), 32'd0);
    check("rst_eng_dec", 32'(eng_dec), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Configuration pulse, then "AB"
    set_cnt = 0;
    pulse_cfg(1'b0);
    tick(3);
    check("set_pulse_len", 32'(set_cnt), 32'd1);
    check("eng_dec_enc", 32'(eng_dec), 32'd0);
    valid_cnt = 0;
    push_str("AB");
    wait_drain(300);
    compare_out("ab");
    check("ab_valids", 32'(valid_cnt), 32'd2);

    // Mixed letters and bypass
    valid_cnt = 0;
    push_str("A-Z");
    wait_drain(300);
    compare_out("a_z");
    check("a_z_valids", 32'(valid_cnt), 32'd2);

    // Timeout: core never answers
    core_respond = 1'b0;
    valid_cnt = 0;
    push_char(8'h51);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid_cnt >= 1) break;
    end
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (err_timeout) break;
    end
    check("tmo_err", 32'(err_timeout), 32'd1);
    check("tmo_window", 32'(lat >= 64 && lat <= 66), 32'd1);
    tick(2);
    check("tmo_idle", 32'(busy), 32'd0);
    check("tmo_no_out", 32'(got_q.size()), 32'd0);
    core_respond = 1'b1;
    pulse_cfg(1'b1);
    tick(2);
    check("tmo_cleared", 32'(err_timeout), 32'd0);
    check("eng_dec_dec", 32'(eng_dec), 32'd1);

    // Output backpressure: 17 letters, 16 fit in the output FIFO
    core_lat = 3;
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      rc = 8'h41 + 8'($urandom_range(0, 25));
      push_char(rc);
      exp_q.push_back(ref_xform(rc, cur_dec));
    end
    tick(400);
    check("bp_nothing_out", 32'(got_q.size()), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_stalled", 32'(busy), 32'd1);
    check("bp_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    wait_drain(500);
    compare_out("bp");

    // Characters pushed while unconfigured wait for cfg_load
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    core_lat = 5;
    valid_cnt = 0;
    cur_dec = 1'b0;
    push_str("K7M");
    tick(20);
    check("uncfg_no_valid", 32'(valid_cnt), 32'd0);
    check("uncfg_no_out", 32'(got_q.size()), 32'd0);
    check("uncfg_busy", 32'(busy), 32'd1);
    pulse_cfg(1'b0);
    wait_drain(300);
    compare_out("uncfg");
    check("uncfg_valids", 32'(valid_cnt), 32'd2);

    // cfg_load while waiting on the core drops the in-flight char
    core_lat = 10;
    valid_cnt = 0;
    push_char(8'h50);
    push_char(8'h51);
    push_char(8'h52);
    exp_q.push_back(ref_xform(8'h51, 1'b0));
    exp_q.push_back(ref_xform(8'h52, 1'b0));
    wait_valid(1);
    tick(2);
    check("midwait_en", 32'(eng_en), 32'd1);
    set_cnt = 0;
    pulse_cfg(1'b0);
    wait_drain(400);
    compare_out("midwait");
    check("midwait_set", 32'(set_cnt), 32'd1);
    check("midwait_valids", 32'(valid_cnt), 32'd3);

    // Asynchronous reset while waiting on the core
    out_ready = 1'b0;
    valid_cnt = 0;
    push_str("ABC");
    exp_q.delete();
    wait_valid(1);
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_eng_en", 32'(eng_en), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(30);
    check("arst_late_done", 32'(got_q.size()), 32'd0);
    check("arst_no_valid", 32'(valid_cnt), 32'd1);
    got_q.delete();

    // Randomized stream with random latency and backpressure
    pulse_cfg(1'($urandom_range(0, 1)));
    tick(2);
    valid_cnt = 0;
    n_let = 0;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: rc = 8'h41 + 8'($urandom_range(0, 25));
            6:                rc = edge_tab[$urandom_range(0, 3)];
            default:          rc = 8'($urandom_range(32, 126));
          endcase
          if (rc >= 8'h41 && rc <= 8'h5A) n_let++;
          push_char(rc);
          exp_q.push_back(ref_xform(rc, cur_dec));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
          core_lat  = $urandom_range(1, 12);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain(3000);
    compare_out("rnd");
    check("rnd_valids", 32'(valid_cnt), 32'(n_let));
    check("rnd_no_err", 32'(err_timeout), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
